// File: rtl/cnn_train_sequencer.sv
// rtl/cnn_train_sequencer.sv - control sequencer for single-image CNN training runs
// Optional: define CNN_SEQ_SKIP_INIT_EN to bypass the random weight init on start.
module cnn_train_sequencer #(
  parameter int CHANNELS      = 10,
  parameter int FCL_INPUT_DIM = 1690,
  parameter int NUM_IMAGES    = 10000,
  parameter int NUM_EPOCHS    = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                start_i,
  input  logic                                train_i,
  input  logic                                pause_i,
  output logic                                img_req_o,
  input  logic                                img_ack_i,
  output logic [$clog2(NUM_IMAGES)-1:0]       img_index_o,
  output logic                                init_we_o,
  output logic                                init_sel_o,
  output logic [$clog2(FCL_INPUT_DIM+1):0]    init_addr_o,
  output logic                                softmax_start_o,
  input  logic                                softmax_done_i,
  output logic                                update_en_o,
  output logic [$clog2(NUM_EPOCHS+1)-1:0]     epoch_o,
  output logic                                busy_o,
  output logic                                run_done_o,
  output logic                                timeout_err_o
);
  localparam int IW   = $clog2(NUM_IMAGES);
  localparam int AW   = $clog2(FCL_INPUT_DIM+1) + 1;
  localparam int EW   = $clog2(NUM_EPOCHS+1);
  localparam int M1   = (CHANNELS > FCL_INPUT_DIM+1) ? CHANNELS : FCL_INPUT_DIM+1;
  localparam int M2   = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX+1);

  localparam logic [CW-1:0] CONV_LAST   = CW'(CHANNELS-1);
  localparam logic [CW-1:0] FCL_LAST    = CW'(FCL_INPUT_DIM);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES-1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT-1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_IMAGES-1);
  localparam logic [EW-1:0] EP_LAST     = EW'(NUM_EPOCHS-1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_CONV, S_INIT_FCL, S_FETCH, S_SETTLE, S_FWD, S_UPDATE, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [EW-1:0] ep_q, ep_d;
  logic          terr_q, terr_d;
  logic          req_q, req_d, we_q, we_d, sel_q, sel_d, ss_q, ss_d;
  logic          upd_q, upd_d, busy_q, busy_d, rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ep_d    = ep_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          idx_d  = '0;
          ep_d   = '0;
          terr_d = 1'b0;
          cnt_d  = '0;
`ifdef CNN_SEQ_SKIP_INIT_EN
          state_d = S_FETCH;
`else
          state_d = S_INIT_CONV;
`endif
        end
      end
      S_INIT_CONV: begin
        if (cnt_q == CONV_LAST) begin
          cnt_d   = '0;
          state_d = S_INIT_FCL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT_FCL: begin
        if (cnt_q == FCL_LAST) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FETCH: begin
        if (img_ack_i) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_FWD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FWD: begin
        // cnt_q==0 is the softmax start cycle; a done seen there is stale
        if (softmax_done_i && cnt_q != '0) begin
          cnt_d   = '0;
          state_d = S_UPDATE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_UPDATE: state_d = S_NEXT;
      S_NEXT: begin
        if (!pause_i) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            ep_d    = ep_q + EW'(1);
            state_d = (ep_q == EP_LAST) ? S_DONE : S_FETCH;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so every output leaves a flop.
    req_d  = (state_d == S_FETCH);
    we_d   = (state_d == S_INIT_CONV) || (state_d == S_INIT_FCL);
    sel_d  = (state_d == S_INIT_FCL);
    addr_d = we_d ? AW'(cnt_d) : '0;
    ss_d   = (state_d == S_FWD) && (state_q != S_FWD);
    upd_d  = (state_q == S_UPDATE) && train_i;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    rd_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ep_q    <= '0;
      terr_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      ss_q    <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ep_q    <= ep_d;
      terr_q  <= terr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      ss_q    <= ss_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
    end
  end

  assign img_req_o       = req_q;
  assign img_index_o     = idx_q;
  assign init_we_o       = we_q;
  assign init_sel_o      = sel_q;
  assign init_addr_o     = addr_q;
  assign softmax_start_o = ss_q;
  assign update_en_o     = upd_q;
  assign epoch_o         = ep_q;
  assign busy_o          = busy_q;
  assign run_done_o      = rd_q;
  assign timeout_err_o   = terr_q;
endmodule

// File: tb/tb_cnn_train_sequencer.sv
// tb/tb_cnn_train_sequencer.sv - randomized plan-based checking of cnn_train_sequencer
module tb_cnn_train_sequencer;
  localparam int CH = 2, FCL = 4, NI = 3, NE = 2, ST = 2, TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, train = 1'b0, pause = 1'b0, img_ack = 1'b0, softmax_done = 1'b0;
  logic img_req, init_we, init_sel, softmax_start, update_en, busy, run_done, timeout_err;
  logic [$clog2(NI)-1:0]    img_index;
  logic [$clog2(FCL+1):0]   init_addr;
  logic [$clog2(NE+1)-1:0]  epoch;

  cnn_train_sequencer #(.CHANNELS(CH), .FCL_INPUT_DIM(FCL), .NUM_IMAGES(NI),
                        .NUM_EPOCHS(NE), .SETTLE_CYCLES(ST), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .train_i(train), .pause_i(pause),
    .img_req_o(img_req), .img_ack_i(img_ack), .img_index_o(img_index),
    .init_we_o(init_we), .init_sel_o(init_sel), .init_addr_o(init_addr),
    .softmax_start_o(softmax_start), .softmax_done_i(softmax_done),
    .update_en_o(update_en), .epoch_o(epoch), .busy_o(busy),
    .run_done_o(run_done), .timeout_err_o(timeout_err));

  always #5 clk = ~clk;

  typedef struct {
    logic rst, st, tr, pa, ak, dn;
    logic chk;
    int   run;
    logic req, we, sel, ss, upd, bsy, rd, terr;
    int   addr, idx, ep;
  } ent_t;
  ent_t plan[$];

  int   cur = -1;
  int   n_chk = 0, n_pass = 0;
  int   m_idx = 0, m_ep = 0, cur_run = 0;
  logic m_terr = 1'b0, m_rd = 1'b0, m_upd = 1'b0;

  int   ss_cnt[8], upd_cnt[8], we_cnt[8], last_ep[8];
  int   ssidx[8][8];
  int   w_sel[8], w_addr[8];
  logic last_rd[8], last_busy[8], last_terr[8];
  int   lsel[7]  = '{0, 0, 1, 1, 1, 1, 1};
  int   laddr[7] = '{0, 1, 0, 1, 2, 3, 4};

  task automatic ck(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s entry=%0d actual=%0d required=%0d", nm, cur, act, exp);
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, st, tr, pa, ak, dn, rq, we, sel, input int addr,
                      input logic ss, bsy);
    ent_t e;
    e.rst = rst; e.st = st; e.tr = tr; e.pa = pa; e.ak = ak; e.dn = dn;
    e.chk = 1'b1; e.run = cur_run;
    e.req = rq; e.we = we; e.sel = sel; e.addr = addr; e.ss = ss; e.bsy = bsy;
    e.idx = m_idx; e.ep = m_ep; e.terr = m_terr; e.rd = m_rd; e.upd = m_upd;
    m_upd = 1'b0;
    plan.push_back(e);
  endtask

  task automatic idle(input logic st);
    push(0, st, rb(), rb(), rb(), rb(), 0, 0, 0, 0, 0, 0);
  endtask

  // One run: optional timeout image, 5-cycle pause image, or reset-abort image.
  task automatic run(input int id, input int mode, input int to_img, input int p5_img, input int ab_img);
    int   n = 0, k, p;
    bit   fin = 0;
    logic t;
    cur_run = id;
    repeat ($urandom_range(1, 3)) idle(1'b0);
    idle(1'b1);
    m_idx = 0; m_ep = 0; m_terr = 1'b0; m_rd = 1'b0;
`ifndef CNN_SEQ_SKIP_INIT_EN
    for (int c = 0; c < CH; c++) push(0, rb(), rb(), rb(), rb(), rb(), 0, 1, 0, c, 0, 1);
    for (int r = 0; r <= FCL; r++) push(0, rb(), rb(), rb(), rb(), rb(), 0, 1, 1, r, 0, 1);
`endif
    while (!fin) begin
      repeat ($urandom_range(0, 3)) push(0, rb(), rb(), rb(), 0, rb(), 1, 0, 0, 0, 0, 1);
      push(0, rb(), rb(), rb(), 1, rb(), 1, 0, 0, 0, 0, 1);
      repeat (ST) push(0, rb(), rb(), rb(), rb(), rb(), 0, 0, 0, 0, 0, 1);
      push(0, rb(), rb(), rb(), rb(), rb(), 0, 0, 0, 0, 1, 1);
      if (n == ab_img) begin
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        m_idx = 0; m_ep = 0; m_terr = 1'b0; m_rd = 1'b0; m_upd = 1'b0;
        push(0, 0, 1, rb(), rb(), 1, 0, 0, 0, 0, 0, 0);
        fin = 1;
      end else if (n == to_img) begin
        repeat (TO - 1) push(0, rb(), rb(), rb(), rb(), 0, 0, 0, 0, 0, 0, 1);
        m_terr = 1'b1; m_rd = 1'b1;
        fin = 1;
      end else begin
        k = $urandom_range(2, TO);
        repeat (k - 2) push(0, rb(), rb(), rb(), rb(), 0, 0, 0, 0, 0, 0, 1);
        push(0, rb(), rb(), rb(), rb(), 1, 0, 0, 0, 0, 0, 1);
        t = (mode == 2) ? rb() : logic'(mode == 1);
        push(0, rb(), t, rb(), rb(), rb(), 0, 0, 0, 0, 0, 1);
        m_upd = t;
        p = (n == p5_img) ? 5 : $urandom_range(0, 2);
        repeat (p) push(0, rb(), rb(), 1, rb(), rb(), 0, 0, 0, 0, 0, 1);
        push(0, rb(), rb(), 0, rb(), rb(), 0, 0, 0, 0, 0, 1);
        if (m_idx == NI - 1) begin
          m_idx = 0;
          m_ep++;
          if (m_ep == NE) begin m_rd = 1'b1; fin = 1; end
        end else begin
          m_idx++;
        end
        n++;
      end
    end
    repeat (2) idle(1'b0);
  endtask

  always @(negedge clk) begin : cmp
    int r;
    if (cur >= 0) begin
      if (plan[cur].chk) begin
        ck("img_req",       img_req,       plan[cur].req);
        ck("img_index",     img_index,     plan[cur].idx);
        ck("init_we",       init_we,       plan[cur].we);
        ck("init_sel",      init_sel,      plan[cur].sel);
        ck("init_addr",     init_addr,     plan[cur].addr);
        ck("softmax_start", softmax_start, plan[cur].ss);
        ck("update_en",     update_en,     plan[cur].upd);
        ck("epoch",         epoch,         plan[cur].ep);
        ck("busy",          busy,          plan[cur].bsy);
        ck("run_done",      run_done,      plan[cur].rd);
        ck("timeout_err",   timeout_err,   plan[cur].terr);
      end
      r = plan[cur].run;
      if (softmax_start) begin
        if (ss_cnt[r] < 8) ssidx[r][ss_cnt[r]] = int'(img_index);
        ss_cnt[r]++;
      end
      if (update_en) upd_cnt[r]++;
      if (init_we) begin
        if (r == 1 && we_cnt[1] < 8) begin
          w_sel[we_cnt[1]]  = int'(init_sel);
          w_addr[we_cnt[1]] = int'(init_addr);
        end
        we_cnt[r]++;
      end
      last_ep[r]   = int'(epoch);
      last_rd[r]   = run_done;
      last_busy[r] = busy;
      last_terr[r] = timeout_err;
    end
  end

  initial begin
    cur_run = 0;
    repeat (3) push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    plan[0].chk = 1'b0;
    run(1, 1, -1, -1, -1);
    run(2, 0, -1, -1, -1);
    run(3, 1, 1, -1, -1);
    run(4, 2, -1, 0, -1);
    run(5, 1, -1, -1, 2);
    run(6, 2, -1, -1, -1);

    for (int t = 0; t < plan.size(); t++) begin
      @(posedge clk);
      #1;
      reset = plan[t].rst; start = plan[t].st; train = plan[t].tr;
      pause = plan[t].pa; img_ack = plan[t].ak; softmax_done = plan[t].dn;
      cur = t;
    end
    @(negedge clk);
    #1;
    cur = -1;

`ifndef CNN_SEQ_SKIP_INIT_EN
    ck("run1_init_beats", we_cnt[1], 7);
    for (int i = 0; i < 7; i++) begin
      ck("run1_init_sel_seq",  w_sel[i],  lsel[i]);
      ck("run1_init_addr_seq", w_addr[i], laddr[i]);
    end
`endif
    ck("run1_updates", upd_cnt[1], 6);
    ck("run1_starts",  ss_cnt[1], 6);
    for (int i = 0; i < 6; i++) ck("run1_index_at_start", ssidx[1][i], i % 3);
    ck("run1_final_epoch", last_ep[1], 2);
    ck("run1_run_done",    last_rd[1], 1);
    ck("run1_busy",        last_busy[1], 0);
    ck("run2_updates", upd_cnt[2], 0);
    ck("run2_starts",  ss_cnt[2], 6);
    ck("run3_updates", upd_cnt[3], 1);
    ck("run3_starts",  ss_cnt[3], 2);
    ck("run3_timeout_err", last_terr[3], 1);
    ck("run3_run_done",    last_rd[3], 1);
    ck("run4_timeout_err_cleared", last_terr[4], 0);
    ck("run5_updates",  upd_cnt[5], 2);
    ck("run5_starts",   ss_cnt[5], 3);
    ck("run5_run_done", last_rd[5], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cnn_train_sequencer.md
Name: cnn_train_sequencer

Overview:
Sequences the single-image CNN datapath (conv, maxpool, flatten, FCL, softmax, loss) through parameter init, image fetch, forward settle, softmax handshake and weight commit. It is a pure control block that owns image index, epoch count and init addressing. The datapath and weight registers sit outside it and are driven by its strobes. It replaces ad-hoc sequencing in the top level and adds epoch control, pause and a softmax watchdog.

Parameters:
CHANNELS, 10, conv kernels to initialise (one init beat each)
FCL_INPUT_DIM, 1690, FCL input rows; init covers FCL_INPUT_DIM+1 rows (bias row included)
NUM_IMAGES, 10000, images per epoch
NUM_EPOCHS, 1, epochs before run completes
SETTLE_CYCLES, 2, cycles after image ack before softmax start (>=1)
TIMEOUT, 1024, max cycles waiting for softmax_done

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin run; sampled in IDLE and DONE only
train  in  1  level; sampled in UPDATE
pause  in  1  level; holds sequencer in NEXT while high
img_req  out  1  image request; held until img_ack
img_ack  in  1  image presented on datapath input this cycle
img_index  out  $clog2(NUM_IMAGES)  current image index
init_we  out  1  random init write strobe
init_sel  out  1  0=conv kernel, 1=FCL row
init_addr  out  $clog2(FCL_INPUT_DIM+1)+1  kernel or row index
softmax_start  out  1  one-cycle start pulse
softmax_done  in  1  softmax result valid
update_en  out  1  one-cycle commit of new weights/kernels
epoch  out  $clog2(NUM_EPOCHS+1)  completed epochs
busy  out  1  high in all states except IDLE, DONE
run_done  out  1  high in DONE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Reset mid-run aborts immediately; no pending strobe survives.
- All outputs are registered.
- States: IDLE, INIT_CONV, INIT_FCL, FETCH, SETTLE, FWD, UPDATE, NEXT, DONE.
- IDLE/DONE: start=1 -> INIT_CONV. img_index, epoch, timeout_err and init_addr are cleared; run_done drops.
- INIT_CONV: init_we=1, init_sel=0, init_addr 0..CHANNELS-1, one per cycle (CHANNELS cycles) -> INIT_FCL.
- INIT_FCL: init_we=1, init_sel=1, init_addr 0..FCL_INPUT_DIM (FCL_INPUT_DIM+1 cycles) -> FETCH.
- init_we is 0 outside the INIT states.
- FETCH: img_req=1 and img_index stable. The cycle img_ack=1 is sampled -> SETTLE with img_req=0 next cycle. img_ack outside FETCH is ignored.
- SETTLE: count SETTLE_CYCLES cycles -> FWD.
- FWD: softmax_start=1 on the first FWD cycle only, then 0. Waits for softmax_done.
  - softmax_done during the start cycle is ignored.
  - softmax_done -> UPDATE.
  - Watchdog counts FWD cycles. At TIMEOUT without done: timeout_err<=1 (sticky until start/reset) -> DONE, no update.
- UPDATE: update_en=1 for exactly one cycle iff train=1 -> NEXT.
- NEXT: if pause=1, stay (img_req=0, no strobes). Otherwise:
  - img_index==NUM_IMAGES-1: img_index<=0, epoch<=epoch+1; new epoch==NUM_EPOCHS -> DONE, else -> FETCH.
  - Otherwise img_index<=img_index+1 -> FETCH.
- DONE: run_done=1, busy=0; img_index and epoch hold final values.
- softmax_done outside FWD, and start outside IDLE/DONE, are ignored.
- Latency per image with img_ack returned the same cycle as img_req: 1 (FETCH) + SETTLE_CYCLES + FWD cycles + 1 (UPDATE) + 1 (NEXT).

Optional Feature:
CNN_SEQ_SKIP_INIT_EN: when defined, start goes directly to FETCH, bypassing INIT_CONV and INIT_FCL. Used for inference or resume with preloaded weights; init_we stays 0. When undefined, the full init sequence runs on every start.

Test Plan:
- CHANNELS=2, FCL_INPUT_DIM=4, pulse start -> init_we high 7 consecutive cycles; init_sel/addr 0/0, 0/1, 1/0..1/4; then img_req=1, img_index=0.
- NUM_IMAGES=3, NUM_EPOCHS=2, SETTLE_CYCLES=2, img_ack same cycle, softmax_done 3 cycles after start, train=1 -> 6 update_en pulses; img_index 0,1,2,0,1,2; epoch 2; run_done=1; busy=0.
- train=0 for the whole run -> zero update_en pulses; softmax_start still pulses once per image (6 total).
- TIMEOUT=8, softmax_done never asserted -> timeout_err=1 on FWD cycle 8, then DONE; no update_en; start clears timeout_err.
- pause=1 held 5 cycles during NEXT after image 1 -> img_index stays 0 and img_req=0 for 5 cycles; resumes with img_index=1 on release.
- reset=1 asserted in the FWD state -> next cycle all outputs 0, state IDLE; a late softmax_done produces no update_en.
